// File: rtl/core_inst_seq.sv
// Instruction sequencer that walks one attention tile (K load, Q exec, drain, acc, div/norm).
// Optional column-combine support is enabled by defining CORE_SEQ_COL_COMBINE_EN.
module core_inst_seq #(
    parameter int COL      = 8,
    parameter int N_Q      = 8,
    parameter int PMEM_LAT = 1,
    parameter int SFP_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        o_valid,
    input  logic        mode_8b,
    output logic [26:0] inst,
    output logic        busy,
    output logic        done,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KLOAD  = 3'd1,
        KDRAIN = 3'd2,
        EXEC   = 3'd3,
        DRAIN  = 3'd4,
        ACC    = 3'd5,
        DIV    = 3'd6,
        FIN    = 3'd7
    } state_t;

    localparam logic [4:0] COL_LAST  = 5'(COL - 1);
    localparam logic [4:0] NQ        = 5'(N_Q);
    localparam logic [4:0] NQ_LAST   = 5'(N_Q - 1);
    localparam logic [4:0] ACC_LAST  = 5'(N_Q + PMEM_LAT - 1);
    localparam logic [4:0] DLAT_BASE = 5'(PMEM_LAT + SFP_LAT);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_d;
    logic        comb_q, comb_d;
    logic [26:0] inst_d;
    logic [4:0]  div_lat;
    logic [4:0]  div_last;
    logic        start_ok;

    // A start during the done cycle is deliberately dropped.
    assign start_ok = (state_q == IDLE) && start && !done;

`ifdef CORE_SEQ_COL_COMBINE_EN
    assign comb_d = start_ok ? mode_8b : comb_q;
`else
    logic unused_mode;
    assign unused_mode = mode_8b;
    assign comb_d      = 1'b0;
`endif

    // The combine register adds one stage between the pmem read and the norm write.
    assign div_lat  = DLAT_BASE + {4'd0, comb_q};
    assign div_last = NQ + div_lat - 5'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        unique case (state_q)
            IDLE: if (start_ok) begin
                state_d = KLOAD;
                cnt_d   = '0;
            end
            KLOAD: if (cnt_q == COL_LAST) begin
                state_d = KDRAIN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            KDRAIN: begin
                state_d = EXEC;
                cnt_d   = '0;
            end
            EXEC: if (cnt_q == NQ_LAST) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            DRAIN: if (cnt_q == NQ) begin
                state_d = ACC;
                cnt_d   = '0;
            end else if (o_valid) begin
                wr_d  = 1'b1;
                cnt_d = cnt_q + 5'd1;
            end
            ACC: if (cnt_q == ACC_LAST) begin
                state_d = DIV;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            DIV: if (cnt_q == div_last) begin
                state_d = FIN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The word is built for the state being entered so it lines up with phase.
    always_comb begin
        inst_d = '0;
        case (state_d)
            KLOAD: begin
                inst_d[3]     = 1'b1;
                inst_d[6]     = 1'b1;
                inst_d[15:12] = cnt_d[3:0];
            end
            EXEC: begin
                inst_d[5]     = 1'b1;
                inst_d[7]     = 1'b1;
                inst_d[15:12] = cnt_d[3:0];
            end
            DRAIN: if (wr_d) begin
                inst_d[16]   = 1'b1;
                inst_d[0]    = 1'b1;
                inst_d[11:8] = cnt_q[3:0];
            end
            ACC: begin
                inst_d[18] = 1'b1;
                inst_d[17] = comb_q;
                if (cnt_d < NQ) begin
                    inst_d[1]    = 1'b1;
                    inst_d[11:8] = cnt_d[3:0];
                end
            end
            DIV: begin
                inst_d[17] = comb_q;
                if (cnt_d < NQ) begin
                    inst_d[1]    = 1'b1;
                    inst_d[19]   = 1'b1;
                    inst_d[20]   = 1'b1;
                    inst_d[11:8] = cnt_d[3:0];
                end
                if (cnt_d >= div_lat) begin
                    inst_d[22]    = 1'b1;
                    inst_d[26:23] = 4'(cnt_d - div_lat);
                end
            end
            default: inst_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            comb_q  <= 1'b0;
            inst    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            comb_q  <= comb_d;
            inst    <= inst_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == FIN);
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: stimulus pushes expected events, a negedge monitor pops them.
module tb_core_inst_seq;
    localparam int COL = 8;
    localparam int N_Q = 8;

    logic        clk = 1'b0;
    logic        reset, start, o_valid, mode_8b;
    logic [26:0] inst;
    logic        busy, done;
    logic [2:0]  phase;

    always #5 clk = ~clk;

    core_inst_seq #(.COL(COL), .N_Q(N_Q), .PMEM_LAT(1), .SFP_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .o_valid(o_valid), .mode_8b(mode_8b),
        .inst(inst), .busy(busy), .done(done), .phase(phase)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ov_at_edge = 1'b0;

    logic [3:0] exp_nrd[$], exp_vrd[$], exp_pwr[$], exp_ard[$], exp_drd[$], exp_nwr[$];
    int rd_cyc[$];
    int exp_done = 0;
    int exp_lag = 2;
    logic exp_colc = 1'b0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ov_at_edge <= o_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int t, input string name, input logic [3:0] act);
        logic [3:0] e;
        logic got;
        got = 1'b0;
        e = '0;
        case (t)
            0: if (exp_nrd.size() > 0) begin e = exp_nrd.pop_front(); got = 1'b1; end
            1: if (exp_vrd.size() > 0) begin e = exp_vrd.pop_front(); got = 1'b1; end
            2: if (exp_pwr.size() > 0) begin e = exp_pwr.pop_front(); got = 1'b1; end
            3: if (exp_ard.size() > 0) begin e = exp_ard.pop_front(); got = 1'b1; end
            4: if (exp_drd.size() > 0) begin e = exp_drd.pop_front(); got = 1'b1; end
            default: if (exp_nwr.size() > 0) begin e = exp_nwr.pop_front(); got = 1'b1; end
        endcase
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: unexpected event at addr %0d, none required (cycle %0d)", name, act, cyc);
        end else if (act !== e) begin
            errors++;
            $display("FAIL %s: addr %0d required %0d (cycle %0d)", name, act, e, cyc);
        end
    endtask

    // Monitor: every output event is matched against the expected queues.
    always @(negedge clk) begin
        chk("forbidden_bits", {29'd0, inst[21], inst[4], inst[2]}, 32'd0);
        chk("ofifo_eq_pmem_wr", {31'd0, inst[16]}, {31'd0, inst[0]});
        chk("col_c", {31'd0, inst[17]}, {31'd0, exp_colc & (inst[18] | inst[19] | inst[22])});
        if (inst[3]) pop_check(0, "nmem_rd", inst[15:12]);
        if (inst[5]) pop_check(1, "vmem_rd", inst[15:12]);
        if (inst[0]) begin
            pop_check(2, "pmem_wr", inst[11:8]);
            chk("pmem_wr_needs_valid", {31'd0, ov_at_edge}, 32'd1);
        end
        if (inst[1] && inst[18]) pop_check(3, "acc_rd", inst[11:8]);
        if (inst[1] && inst[19]) begin
            pop_check(4, "div_rd", inst[11:8]);
            rd_cyc.push_back(cyc);
        end
        if (inst[22]) begin
            pop_check(5, "norm_wr", inst[26:23]);
            if (rd_cyc.size() > 0) chk("norm_wr_lag", cyc - rd_cyc.pop_front(), exp_lag);
        end
        if (done) begin
            chk("done_idle", {28'd0, busy, phase}, 32'd0);
            checks++;
            if (exp_done == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected done (cycle %0d)", cyc);
            end else begin
                exp_done--;
            end
        end
    end

    task automatic push_tile(input logic m);
        for (int k = 0; k < COL; k++) exp_nrd.push_back(4'(k));
        for (int q = 0; q < N_Q; q++) begin
            exp_vrd.push_back(4'(q));
            exp_pwr.push_back(4'(q));
            exp_ard.push_back(4'(q));
            exp_drd.push_back(4'(q));
            exp_nwr.push_back(4'(q));
        end
        exp_done++;
`ifdef CORE_SEQ_COL_COMBINE_EN
        exp_lag  = m ? 3 : 2;
        exp_colc = m;
`else
        exp_lag  = 2;
        exp_colc = 1'b0;
`endif
    endtask

    task automatic clear_exp();
        exp_nrd.delete(); exp_vrd.delete(); exp_pwr.delete();
        exp_ard.delete(); exp_drd.delete(); exp_nwr.delete();
        rd_cyc.delete();
        exp_done = 0;
    endtask

    function automatic int pending();
        return exp_nrd.size() + exp_vrd.size() + exp_pwr.size() + exp_ard.size()
             + exp_drd.size() + exp_nwr.size();
    endfunction

    // Runs until done is seen; ov_mode 1 drives the 1,0,0 o_valid pattern.
    task automatic wait_done(input int ov_mode, input bit poke);
        bit seen;
        int pat;
        seen = 1'b0;
        pat = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            o_valid = (ov_mode == 0) ? 1'b1 : (pat == 0);
            pat = (pat == 2) ? 0 : pat + 1;
            if (poke) start = (phase == 3'd1) || (phase == 3'd3) || done;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tile_timeout", {31'd0, seen}, 32'd1);
        chk("queues_drained", pending(), 0);
    endtask

    task automatic run_tile(input int ov_mode, input logic m, input bit poke);
        push_tile(m);
        @(posedge clk); #1;
        start   = 1'b1;
        mode_8b = m;
        @(posedge clk); #1;
        start   = 1'b0;
        mode_8b = 1'b0;
        chk("start_accept", {29'd0, phase}, 32'd1);
        wait_done(ov_mode, poke);
    endtask

    initial begin
        bit hit;
        reset   = 1'b1;
        start   = 1'b1;
        o_valid = 1'b1;
        mode_8b = 1'b0;

        // Reset held with start high; tile begins once reset drops.
        push_tile(1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_inst", {5'd0, inst}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_phase", {29'd0, phase}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t1_kload", {29'd0, phase}, 32'd1);
        wait_done(0, 1'b0);

        // Back-to-back tile: start one cycle after done.
        run_tile(0, 1'b0, 1'b0);

        // DRAIN stalls with o_valid 1,0,0.
        run_tile(1, 1'b0, 1'b0);

        // Start pokes during KLOAD, EXEC and the done cycle.
        run_tile(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_restart", {29'd0, phase}, 32'd0);
        chk("single_done", exp_done, 0);

        // Abort with reset at DIV row 3.
        push_tile(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (phase == 3'd6 && inst[19] && inst[11:8] == 4'd3) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_div_row3", {31'd0, hit}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        clear_exp();
        @(negedge clk);
        chk("abort_inst", {5'd0, inst}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_phase", {29'd0, phase}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_idle", {29'd0, phase}, 32'd0);
        run_tile(0, 1'b0, 1'b0);

        // mode_8b requested at start.
        run_tile(0, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("done_count", exp_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
